// File: rtl/control_sequencer.sv
// Hardwired control unit for the Phase-2 Datapath: fetch T0-T2, execute T3-T7.
// Outputs are Moore decodes of the registered state and the opcode held in IR.
module control_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZLO_Out,
    output logic        C_Out,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        MAR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZLO_In,
    output logic        G_RA,
    output logic        G_RB,
    output logic        G_RC,
    output logic        BA_Out,
    output logic        R_In,
    output logic        R_Out,
    output logic [4:0]  CONTROL,
    output logic        Run,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_wait;
    logic [4:0]  w_op;
    logic        w_ld, w_ldi, w_st, w_alu, w_imm, w_nop, w_halt, w_exec;
    logic        w_wait_done;

    assign w_op        = IR[31:27];
    assign w_ld        = (w_op == 5'b00000);
    assign w_ldi       = (w_op == 5'b00001);
    assign w_st        = (w_op == 5'b00010);
    assign w_alu       = (w_op >= 5'b00011) && (w_op <= 5'b01011);
    assign w_imm       = (w_op >= 5'b01100) && (w_op <= 5'b01110);
    assign w_nop       = (w_op == 5'b11010);
    assign w_halt      = (w_op == 5'b11011);
    assign w_exec      = w_ld | w_ldi | w_st | w_alu | w_imm;
    assign w_wait_done = (r_wait == 3'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = w_wait_done ? S_T2 : S_T1;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = w_halt ? S_HALT : (w_exec ? S_T4 : S_T0);
            S_T4:    w_next = S_T5;
            S_T5:    w_next = (w_ld | w_st) ? S_T6 : S_T0;
            S_T6:    w_next = (w_ld && !w_wait_done) ? S_T6 : S_T7;
            S_T7:    w_next = (w_st && !w_wait_done) ? S_T7 : S_T0;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

    // The wait counter reloads on every state change, so it is already at
    // MEM_WAIT on entry to whichever memory state comes next.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state <= S_RESET;
            r_wait  <= WAIT_INIT;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= WAIT_INIT;
            else if (!w_wait_done)
                r_wait <= r_wait - 3'd1;
        end
    end

    always_comb begin
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        C_Out   = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        MAR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        G_RA    = 1'b0;
        G_RB    = 1'b0;
        G_RC    = 1'b0;
        BA_Out  = 1'b0;
        R_In    = 1'b0;
        R_Out   = 1'b0;
        CONTROL = 5'b00000;
        Run     = 1'b0;
        Illegal = 1'b0;
        case (r_state)
            S_T0: begin
                Run = 1'b1; PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; Read = 1'b1; MDR_In = 1'b1;
            end
            S_T2: begin
                Run = 1'b1; MDR_Out = 1'b1; IR_In = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (w_ld | w_ldi | w_st) begin
                    G_RB = 1'b1; BA_Out = 1'b1; Y_In = 1'b1;
                end else if (w_alu | w_imm) begin
                    G_RB = 1'b1; R_Out = 1'b1; Y_In = 1'b1;
                end else if (!w_nop && !w_halt) begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                Run    = 1'b1;
                ZLO_In = 1'b1;
                if (w_alu) begin
                    G_RC = 1'b1; R_Out = 1'b1; CONTROL = w_op;
                end else begin
                    C_Out = 1'b1;
                    // andi/ori map onto the register and/or ALU codes
                    case (w_op)
                        5'b01101: CONTROL = 5'b00101;
                        5'b01110: CONTROL = 5'b00110;
                        default:  CONTROL = 5'b00011;
                    endcase
                end
            end
            S_T5: begin
                Run     = 1'b1;
                ZLO_Out = 1'b1;
                if (w_ld | w_st) MAR_In = 1'b1;
                else begin
                    G_RA = 1'b1; R_In = 1'b1;
                end
            end
            S_T6: begin
                Run    = 1'b1;
                MDR_In = 1'b1;
                if (w_ld) Read = 1'b1;
                else begin
                    G_RA = 1'b1; R_Out = 1'b1;
                end
            end
            S_T7: begin
                Run     = 1'b1;
                MDR_Out = 1'b1;
                if (w_st) Write = 1'b1;
                else begin
                    G_RA = 1'b1; R_In = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: two sequencers (MEM_WAIT 0 and 2) run directed and random
// programs; expected per-cycle control words come from an instruction-level model.
module tb_control_sequencer;

    localparam logic [25:0] B_INC  = 26'd1 << 25;
    localparam logic [25:0] B_RD   = 26'd1 << 24;
    localparam logic [25:0] B_WR   = 26'd1 << 23;
    localparam logic [25:0] B_PCO  = 26'd1 << 22;
    localparam logic [25:0] B_MDRO = 26'd1 << 21;
    localparam logic [25:0] B_ZO   = 26'd1 << 20;
    localparam logic [25:0] B_CO   = 26'd1 << 19;
    localparam logic [25:0] B_MDRI = 26'd1 << 17;
    localparam logic [25:0] B_MARI = 26'd1 << 16;
    localparam logic [25:0] B_IRI  = 26'd1 << 15;
    localparam logic [25:0] B_YI   = 26'd1 << 14;
    localparam logic [25:0] B_ZI   = 26'd1 << 13;
    localparam logic [25:0] B_GRA  = 26'd1 << 12;
    localparam logic [25:0] B_GRB  = 26'd1 << 11;
    localparam logic [25:0] B_GRC  = 26'd1 << 10;
    localparam logic [25:0] B_BA   = 26'd1 << 9;
    localparam logic [25:0] B_RIN  = 26'd1 << 8;
    localparam logic [25:0] B_ROUT = 26'd1 << 7;
    localparam logic [25:0] B_RUN  = 26'd1 << 1;
    localparam logic [25:0] B_ILL  = 26'd1;

    logic        Clock = 1'b0;
    logic        clr0 = 1'b1, clr1 = 1'b1;
    logic [31:0] ir0 = 32'h0, ir1 = 32'h0;
    wire  [25:0] ov0, ov1;

    logic [25:0] expq0[$], expq1[$];
    logic [31:0] prog0[$], prog1[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    control_sequencer #(.MEM_WAIT(0)) dut0 (
        .Clock(Clock), .Clear(clr0), .IR(ir0),
        .IncPC(ov0[25]), .Read(ov0[24]), .Write(ov0[23]), .PC_Out(ov0[22]),
        .MDR_Out(ov0[21]), .ZLO_Out(ov0[20]), .C_Out(ov0[19]), .PC_In(ov0[18]),
        .MDR_In(ov0[17]), .MAR_In(ov0[16]), .IR_In(ov0[15]), .Y_In(ov0[14]),
        .ZLO_In(ov0[13]), .G_RA(ov0[12]), .G_RB(ov0[11]), .G_RC(ov0[10]),
        .BA_Out(ov0[9]), .R_In(ov0[8]), .R_Out(ov0[7]), .CONTROL(ov0[6:2]),
        .Run(ov0[1]), .Illegal(ov0[0])
    );

    control_sequencer #(.MEM_WAIT(2)) dut2 (
        .Clock(Clock), .Clear(clr1), .IR(ir1),
        .IncPC(ov1[25]), .Read(ov1[24]), .Write(ov1[23]), .PC_Out(ov1[22]),
        .MDR_Out(ov1[21]), .ZLO_Out(ov1[20]), .C_Out(ov1[19]), .PC_In(ov1[18]),
        .MDR_In(ov1[17]), .MAR_In(ov1[16]), .IR_In(ov1[15]), .Y_In(ov1[14]),
        .ZLO_In(ov1[13]), .G_RA(ov1[12]), .G_RB(ov1[11]), .G_RC(ov1[10]),
        .BA_Out(ov1[9]), .R_In(ov1[8]), .R_Out(ov1[7]), .CONTROL(ov1[6:2]),
        .Run(ov1[1]), .Illegal(ov1[0])
    );

    // Emulates the datapath's IR register: loads the next program word on IR_In.
    always @(posedge Clock) begin
        if (ov0[15]) ir0 <= (prog0.size() != 0) ? prog0.pop_front() : 32'hD8000000;
        if (ov1[15]) ir1 <= (prog1.size() != 0) ? prog1.pop_front() : 32'hD8000000;
    end

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (expq0.size() != 0) check("mw0_cycle", ov0, expq0.pop_front());
        if (expq1.size() != 0) check("mw2_cycle", ov1, expq1.pop_front());
    end

    function automatic logic [25:0] ctl(input logic [4:0] c);
        return {19'b0, c, 2'b0};
    endfunction

    task automatic q_push(input int w, input logic [25:0] v);
        if (w == 0) expq0.push_back(v); else expq1.push_back(v);
    endtask

    function automatic int q_size(input int w);
        return (w == 0) ? expq0.size() : expq1.size();
    endfunction

    task automatic set_clear(input int w, input logic v);
        if (w == 0) clr0 = v; else clr1 = v;
    endtask

    function automatic logic [25:0] obs(input int w);
        return (w == 0) ? ov0 : ov1;
    endfunction

    // Instruction-level model: the whole cycle-by-cycle control word stream of
    // one instruction; only the first lim words are queued.
    task automatic push_instr(input int w, input logic [31:0] ir, input int mw, input int lim);
        logic [25:0] seq[$];
        logic [4:0]  op;
        logic [4:0]  c;
        op = ir[31:27];
        if (w == 0) prog0.push_back(ir); else prog1.push_back(ir);
        seq.push_back(B_PCO | B_MARI | B_INC);
        for (int k = 0; k <= mw; k++) seq.push_back(B_RD | B_MDRI);
        seq.push_back(B_MDRO | B_IRI);
        if (op <= 5'd2) begin
            seq.push_back(B_GRB | B_BA | B_YI);
            seq.push_back(B_CO | B_ZI | ctl(5'd3));
            if (op == 5'd1) seq.push_back(B_ZO | B_GRA | B_RIN);
            else seq.push_back(B_ZO | B_MARI);
            if (op == 5'd0) begin
                for (int k = 0; k <= mw; k++) seq.push_back(B_RD | B_MDRI);
                seq.push_back(B_MDRO | B_GRA | B_RIN);
            end else if (op == 5'd2) begin
                seq.push_back(B_GRA | B_ROUT | B_MDRI);
                for (int k = 0; k <= mw; k++) seq.push_back(B_MDRO | B_WR);
            end
        end else if (op <= 5'd11) begin
            seq.push_back(B_GRB | B_ROUT | B_YI);
            seq.push_back(B_GRC | B_ROUT | B_ZI | ctl(op));
            seq.push_back(B_ZO | B_GRA | B_RIN);
        end else if (op <= 5'd14) begin
            c = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
            seq.push_back(B_GRB | B_ROUT | B_YI);
            seq.push_back(B_CO | B_ZI | ctl(c));
            seq.push_back(B_ZO | B_GRA | B_RIN);
        end else if (op == 5'd26 || op == 5'd27) begin
            seq.push_back('0);
        end else begin
            seq.push_back(B_ILL);
        end
        for (int k = 0; k < seq.size() && k < lim; k++) q_push(w, seq[k] | B_RUN);
    endtask

    task automatic drain(input int w);
        int g;
        g = 0;
        while (q_size(w) != 0) begin
            @(negedge Clock);
            #1;
            g++;
            if (g > 5000) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_timeout dut%0d: %0d entries left, required 0", w, q_size(w));
                if (w == 0) expq0.delete(); else expq1.delete();
            end
        end
    endtask

    task automatic clear_pulse(input int w);
        set_clear(w, 1'b1);
        q_push(w, '0);
        q_push(w, '0);
        drain(w);
        set_clear(w, 1'b0);
    endtask

    task automatic run_seq(input int w, input int mw);
        logic [4:0]  op;
        logic [31:0] ir;
        // held in reset from time 0
        for (int k = 0; k < 3; k++) q_push(w, '0);
        drain(w);
        set_clear(w, 1'b0);
        push_instr(w, 32'h1088005A, mw, 99);
        push_instr(w, 32'h0088005A, mw, 99);
        push_instr(w, 32'h19890000, mw, 99);
        push_instr(w, 32'hD8000000, mw, 99);
        for (int k = 0; k < 4; k++) q_push(w, '0);
        drain(w);

        clear_pulse(w);
        for (int n = 0; n < 25; n++) begin
            do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
            ir = {op, 27'($urandom)};
            push_instr(w, ir, mw, 99);
        end
        push_instr(w, 32'hD8000000, mw, 99);
        for (int k = 0; k < 3; k++) q_push(w, '0);
        drain(w);

        // abort ld in T5
        clear_pulse(w);
        push_instr(w, 32'h0088005A, mw, mw + 5);
        drain(w);
        @(posedge Clock);
        #1;
        check("abort_in_t5", obs(w), B_RUN | B_ZO | B_MARI);
        set_clear(w, 1'b1);
        #1;
        check("abort_async_clear", obs(w), '0);
        q_push(w, '0);
        drain(w);
        set_clear(w, 1'b0);
        push_instr(w, 32'h61000000, mw, 99);
        push_instr(w, 32'hD8000000, mw, 99);
        for (int k = 0; k < 3; k++) q_push(w, '0);
        drain(w);
    endtask

    initial begin
        fork
            run_seq(0, 0);
            run_seq(1, 2);
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
